// File: rtl/core_mem_sequencer.sv
`default_nettype none
// ============================================================================
// core_mem_sequencer : multi-cycle FETCH/EXEC/DATA/COMMIT controller over one
// shared req/ready memory bus. Optional macro BUS_TIMEOUT_EN: bus wait limit.
// Revision: 1.0 - initial release
// ============================================================================

module core_mem_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_data2_in,
  input  logic        mem_write_in,
  input  logic        halt_in,
  output logic [31:0] instr_out,
  output logic [31:0] mem_out,
  output logic        core_step,
  output logic [31:0] pc_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [31:0] instret,
  output logic        bus_err
);

  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic w_busy;
  logic w_is_load;
  logic w_timeout;

  assign w_busy    = (state_q == ST_FETCH) || (state_q == ST_DATA);
  assign w_is_load = (instr_q[6:0] == c_OP_LOAD);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    mem_out_d = mem_out_q;
    instret_d = instret_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH: begin
        addr_d = pc_q;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = ST_EXEC;
        end else if (w_timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (halt_in)                        state_d = ST_HALT;
        else if (mem_write_in || w_is_load) state_d = ST_DATA;
        else                                state_d = ST_COMMIT;
      end
      ST_DATA: begin
        mem_we  = mem_write_in;
        addr_d  = alu_result_in;
        wdata_d = reg_data2_in;
        if (mem_ready) begin
          if (w_is_load) mem_out_d = mem_rdata;
          state_d = ST_COMMIT;
        end else if (w_timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_COMMIT: begin
        pc_d      = npc_in;
        instret_d = instret_q + 32'd1;
        state_d   = ST_FETCH;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Bus address/data are the next-hold values so they persist once the request drops.
  assign mem_req   = w_busy;
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= c_NOP_INSTR;
      mem_out_q <= 32'd0;
      instret_q <= 32'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      mem_out_q <= mem_out_d;
      instret_q <= instret_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic                bus_err_q, bus_err_d;

  // Counter idles at zero, so every new request starts from a cleared count.
  always_comb begin
    wait_d    = '0;
    bus_err_d = bus_err_q;
    w_timeout = 1'b0;
    if (w_busy && !mem_ready) begin
      if (wait_q == c_WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        w_timeout = 1'b1;
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign bus_err          = 1'b0;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  assign instr_out = instr_q;
  assign mem_out   = mem_out_q;
  assign pc_out    = pc_q;
  assign instret   = instret_q;
  assign core_step = (state_q == ST_COMMIT);
  assign halted    = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_core_mem_sequencer.sv
`default_nettype none
// ============================================================================
// tb_core_mem_sequencer : directed table plus randomized instruction stream
// against a transaction-level model of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================

module tb_core_mem_sequencer;

  localparam logic [31:0] RESET_PC       = 32'h0000_0000;
  localparam int          TIMEOUT_CYCLES = 4;
  localparam logic [31:0] NOP            = 32'h0000_0013;
`ifdef BUS_TIMEOUT_EN
  localparam int          STALL_CYCLES   = 3;
`else
  localparam int          STALL_CYCLES   = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in, alu_result_in, reg_data2_in;
  logic        mem_write_in, halt_in;
  logic [31:0] instr_out, mem_out, pc_out, mem_addr, mem_wdata, mem_rdata, instret;
  logic        core_step, mem_req, mem_we, mem_ready, halted, bus_err;

  core_mem_sequencer #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .npc_in        (npc_in),
    .alu_result_in (alu_result_in),
    .reg_data2_in  (reg_data2_in),
    .mem_write_in  (mem_write_in),
    .halt_in       (halt_in),
    .instr_out     (instr_out),
    .mem_out       (mem_out),
    .core_step     (core_step),
    .pc_out        (pc_out),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .halted        (halted),
    .instret       (instret),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          store;
    bit          halt;
    logic [31:0] npc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          fw;
    int          dw;
    logic [31:0] x_pc;
    logic [31:0] x_mem_out;
    logic [31:0] x_instret;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int step_cnt = 0;
  int exp_steps = 0;

  logic [31:0] exp_pc, exp_instret, exp_mem_out, exp_last_addr;

  always @(negedge clk) if (core_step === 1'b1) step_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input bit st, input bit h,
                              input logic [31:0] npc, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int fw, input int dw, input logic [31:0] x_pc,
                              input logic [31:0] x_mem_out, input logic [31:0] x_instret);
    vec_t v;
    v.instr = instr; v.store = st; v.halt = h; v.npc = npc; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.fw = fw; v.dw = dw;
    v.x_pc = x_pc; v.x_mem_out = x_mem_out; v.x_instret = x_instret;
    return v;
  endfunction

  // Asynchronous reset: outputs are checked before any clock edge occurs.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk ("rst_pc",      pc_out,    RESET_PC);
    chk ("rst_instr",   instr_out, NOP);
    chk ("rst_mem_out", mem_out,   32'd0);
    chk ("rst_instret", instret,   32'd0);
    chk ("rst_addr",    mem_addr,  32'd0);
    chk ("rst_wdata",   mem_wdata, 32'd0);
    chkb("rst_req",     mem_req,   1'b0);
    chkb("rst_we",      mem_we,    1'b0);
    chkb("rst_step",    core_step, 1'b0);
    chkb("rst_halted",  halted,    1'b0);
    chkb("rst_bus_err", bus_err,   1'b0);
    exp_pc = RESET_PC; exp_instret = 32'd0; exp_mem_out = 32'd0; exp_last_addr = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chkb("boot_req", mem_req, 1'b0);
    @(negedge clk);
  endtask

  // Runs one instruction starting at the negedge of its FETCH cycle.
  task automatic run_instr(input vec_t t);
    bit is_load, mem_op;
    is_load = (t.instr[6:0] == 7'b0000011);
    mem_op  = is_load || t.store;
    npc_in = t.npc; alu_result_in = t.addr; reg_data2_in = t.wdata;
    mem_write_in = t.store; halt_in = t.halt;
    for (int w = 0; w <= t.fw; w++) begin
      chkb("fetch_req",  mem_req,   1'b1);
      chk ("fetch_addr", mem_addr,  exp_pc);
      chkb("fetch_we",   mem_we,    1'b0);
      chkb("fetch_step", core_step, 1'b0);
      mem_ready = (w == t.fw);
      mem_rdata = mem_ready ? t.instr : $urandom();
      @(negedge clk);
    end
    exp_last_addr = exp_pc;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom();
    chkb("exec_req",   mem_req,   1'b0);
    chkb("exec_we",    mem_we,    1'b0);
    chk ("exec_addr",  mem_addr,  exp_last_addr);
    chk ("exec_instr", instr_out, t.instr);
    chkb("exec_step",  core_step, 1'b0);
    @(negedge clk);
    if (t.halt) begin
      mem_ready = 1'b0;
      return;
    end
    if (mem_op) begin
      for (int w = 0; w <= t.dw; w++) begin
        chkb("data_req",   mem_req,   1'b1);
        chk ("data_addr",  mem_addr,  t.addr);
        chkb("data_we",    mem_we,    t.store);
        chk ("data_wdata", mem_wdata, t.wdata);
        chkb("data_step",  core_step, 1'b0);
        mem_ready = (w == t.dw);
        mem_rdata = mem_ready ? t.rdata : $urandom();
        @(negedge clk);
      end
      exp_last_addr = t.addr;
      if (is_load) exp_mem_out = t.rdata;
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom();
    chkb("commit_step",    core_step, 1'b1);
    chkb("commit_req",     mem_req,   1'b0);
    chk ("commit_instr",   instr_out, t.instr);
    chk ("commit_mem_out", mem_out,   exp_mem_out);
    chk ("commit_addr",    mem_addr,  exp_last_addr);
    chk ("commit_pc",      pc_out,    exp_pc);
    exp_pc = t.npc;
    exp_instret = exp_instret + 32'd1;
    exp_steps++;
    @(negedge clk);
    mem_ready = 1'b0;
    chk ("next_pc",      pc_out,    exp_pc);
    chk ("next_instret", instret,   exp_instret);
    chkb("next_step",    core_step, 1'b0);
    chkb("next_bus_err", bus_err,   1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t, limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir [6];
    vec_t post [2];
    vec_t v;
    int   kind;

    dir[0] = mk(32'h0050_0093, 0, 0, 32'h0000_0004, 32'h0, 32'h0, 32'h0,
                0, 0, 32'h0000_0004, 32'h0000_0000, 32'd1);
    dir[1] = mk(32'h0000_A283, 0, 0, 32'h0000_0008, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
                0, 2, 32'h0000_0008, 32'hDEAD_BEEF, 32'd2);
    dir[2] = mk(32'h00B5_2023, 1, 0, 32'h0000_000C, 32'h0000_0200, 32'h1234_5678, 32'h5555_AAAA,
                1, 0, 32'h0000_000C, 32'hDEAD_BEEF, 32'd3);
    dir[3] = mk(32'h0000_0063, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 32'h0,
                0, 0, 32'h0000_0040, 32'hDEAD_BEEF, 32'd4);
    dir[4] = mk(32'h0000_006F, 0, 0, 32'h0000_0123, 32'h0, 32'h0, 32'h0,
                2, 0, 32'h0000_0123, 32'hDEAD_BEEF, 32'd5);
    dir[5] = mk(32'h0010_0113, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,
                0, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'd6);

    npc_in = 32'd0; alu_result_in = 32'd0; reg_data2_in = 32'd0;
    mem_write_in = 1'b0; halt_in = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    reset = 1'b0;
    #1;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_instr(dir[i]);
      chk("tbl_pc",      pc_out,  dir[i].x_pc);
      chk("tbl_mem_out", mem_out, dir[i].x_mem_out);
      chk("tbl_instret", instret, dir[i].x_instret);
    end

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      v.instr = $urandom();
      case (kind)
        1:       v.instr[6:0] = 7'b0000011;
        2:       v.instr[6:0] = 7'b0100011;
        default: if (v.instr[6:0] == 7'b0000011) v.instr[6:0] = 7'b0010011;
      endcase
      v.store = (kind == 2);
      v.halt  = 1'b0;
      v.npc   = (kind == 3) ? $urandom() : exp_pc + 32'd4;
      v.addr  = $urandom();
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.fw    = int'($urandom_range(0, 3));
      v.dw    = int'($urandom_range(0, 3));
      run_instr(v);
    end

    // Store stalled in DATA, then reset lands between clock edges.
    npc_in = exp_pc + 32'd4; alu_result_in = 32'hA5A5_0F00; reg_data2_in = 32'hCAFE_F00D;
    mem_write_in = 1'b1; halt_in = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h00C5_2223;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < STALL_CYCLES; i++) begin
      chkb("stall_req",    mem_req,   1'b1);
      chk ("stall_addr",   mem_addr,  32'hA5A5_0F00);
      chkb("stall_we",     mem_we,    1'b1);
      chk ("stall_wdata",  mem_wdata, 32'hCAFE_F00D);
      chkb("stall_halted", halted,    1'b0);
      chkb("stall_step",   core_step, 1'b0);
      @(negedge clk);
    end
    #2;
    do_reset();

    post[0] = mk(32'h0000_A303, 0, 0, 32'h0000_0004, 32'h0000_0800, 32'h0, 32'h0BAD_F00D,
                 1, 1, 32'h0000_0004, 32'h0BAD_F00D, 32'd1);
    post[1] = mk(32'h0010_0073, 0, 1, 32'h0000_0099, 32'h0, 32'h0, 32'h0,
                 0, 0, 32'h0000_0004, 32'h0BAD_F00D, 32'd1);
    for (int i = 0; i < 2; i++) begin
      run_instr(post[i]);
      chk("tbl_pc",      pc_out,  post[i].x_pc);
      chk("tbl_mem_out", mem_out, post[i].x_mem_out);
      chk("tbl_instret", instret, post[i].x_instret);
    end

    for (int i = 0; i < 6; i++) begin
      chkb("halt_halted",  halted,    1'b1);
      chkb("halt_req",     mem_req,   1'b0);
      chkb("halt_step",    core_step, 1'b0);
      chk ("halt_instret", instret,   exp_instret);
      chk ("halt_pc",      pc_out,    exp_pc);
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
      @(negedge clk);
    end
    mem_ready = 1'b0;
    halt_in = 1'b0;
    #2;
    do_reset();
    chk("after_halt_pc", pc_out, RESET_PC);

`ifdef BUS_TIMEOUT_EN
    // Fetch that never gets mem_ready.
    begin
      int steps_before;
      steps_before = step_cnt;
      mem_ready = 1'b0;
      for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
        @(negedge clk);
        chkb("to_wait_halted", halted,  1'b0);
        chkb("to_wait_err",    bus_err, 1'b0);
        chkb("to_wait_req",    mem_req, 1'b1);
      end
      @(negedge clk);
      chkb("to_halted",  halted,    1'b1);
      chkb("to_bus_err", bus_err,   1'b1);
      chkb("to_req",     mem_req,   1'b0);
      chk ("to_instr",   instr_out, NOP);
      chk ("to_instret", instret,   32'd0);
      repeat (3) @(negedge clk);
      chkb("to_err_sticky", bus_err, 1'b1);
      chk ("to_steps", 32'(step_cnt - steps_before), 32'd0);
      #2;
      do_reset();
    end
`endif

    chk("total_steps", 32'(step_cnt), 32'(exp_steps));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
